vga_text_buf: RTL and testbench
===============================

Name: vga_text_buf

Overview:
- Parametrised character/attribute buffer for the VGA text console. Successor to the fixed 70x29 character memory.
- Read port: registered, addressed by the scan logic in logical (row, col).
- Write port: valid/ready, driven by the terminal/CPU side.
- Internal command engine performs hardware clear and one-line hardware scroll via a rotating top-row pointer, so software never rewrites the whole screen.

Parameters:
- ROWS, 30, text rows
- COLS, 70, text columns
- CLR_W, 3, width of each fg/bg colour field
- BLANK, 8'h20, fill character used by clear/scroll
- RW, $clog2(ROWS), row index width (derived)
- CW, $clog2(COLS), column index width (derived)

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- r_row  in  RW  logical read row
- r_col  in  CW  logical read column
- rd_ascii  out  8  registered character
- rd_fg  out  CLR_W  registered foreground colour
- rd_bg  out  CLR_W  registered background colour
- rd_cursor  out  1  registered cursor-hit flag
- w_valid  in  1  write request
- w_ready  out  1  write accepted this cycle when high with w_valid
- w_row  in  RW  logical write row
- w_col  in  CW  logical write column
- w_ascii  in  8  character to write
- w_fg  in  CLR_W  foreground colour to write
- w_bg  in  CLR_W  background colour to write
- cmd_clear  in  1  one-cycle pulse: fill whole screen
- cmd_scroll  in  1  one-cycle pulse: scroll up one line
- fill_fg  in  CLR_W  fill foreground colour, sampled at command start
- fill_bg  in  CLR_W  fill background colour, sampled at command start
- cur_row  in  RW  cursor row
- cur_col  in  CW  cursor column
- frame_tick  in  1  one pulse per frame
- busy  out  1  command engine active
- top_row  out  RW  physical row currently shown as logical row 0

Behaviour:
- Storage: ROWS*COLS cells of {ascii, fg, bg}.
  - Physical address = phys_row*COLS + col.
  - phys_row = (logical_row + top_row) mod ROWS, computed without a divider (compare-and-subtract).
  - Memory contents are not reset.
- Read: 1-cycle latency. Outputs reflect the cell addressed on the previous clk edge.
  - Out-of-range row/col returns {BLANK, 0, 0}.
  - Reads are always serviced, including while busy.
- Write: occurs when w_valid && w_ready.
  - w_ready = (state==IDLE) && !cmd_clear && !cmd_scroll.
  - Out-of-range coordinates are accepted (handshake completes) but nothing is written.
  - Read and write of the same cell on the same edge returns the old data.
- FSM states and transitions:
  - IDLE:
    - cmd_clear -> CLEAR: latch fill colours, top_row<=0, counter<=0.
    - else cmd_scroll -> SCROLL: top_row<=(top_row+1) mod ROWS, counter<=0. The new bottom physical row is the old top_row.
    - cmd_clear and cmd_scroll together: clear wins, scroll is dropped.
  - CLEAR: write one BLANK cell per cycle at linear address counter. After ROWS*COLS cycles -> IDLE.
  - SCROLL: blank the physical row equal to the old top_row, one cell per cycle. After COLS cycles -> IDLE.
  - Commands arriving while busy are ignored.
- busy = (state!=IDLE).
- Reset: state IDLE, top_row 0, busy 0, counters 0, rd_ascii/rd_fg/rd_bg/rd_cursor 0. A reset in the middle of a command leaves memory partially filled.

Optional Feature:
- VGA_TEXT_CURSOR_EN defined:
  - A 5-bit frame counter increments on each frame_tick; blink phase = counter[4].
  - rd_cursor = registered (r_row==cur_row && r_col==cur_col && phase).
- Not defined: rd_cursor is constant 0, and cur_row, cur_col and frame_tick are unused.

Decomposition:
- Package vga_text_pkg holds:
  - the cell struct typedef {ascii, fg, bg}
  - the FSM state enum (IDLE, CLEAR, SCROLL)
  - default ROWS/COLS/BLANK constants
- Sub-module vga_text_ram: simple dual-port RAM with one registered read port and one write port, depth ROWS*COLS. The write port is muxed between the user path and the command engine.

Test Plan:
- Write (2,5) 'A' fg=7 bg=1, then read (2,5) -> one cycle later rd_ascii=8'h41, rd_fg=7, rd_bg=1.
- cmd_clear with fill 0/2 -> busy high for exactly 2100 cycles (30x70), w_ready low throughout; every cell then reads 8'h20/0/2.
- Write 'X' at logical row 1, then cmd_scroll:
  - busy high for 70 cycles, top_row 0->1.
  - 'X' now reads at logical row 0.
  - Logical row 29 is all BLANK.
- 30 consecutive scrolls -> top_row wraps to 0. cmd_clear and cmd_scroll in the same cycle -> clear only, top_row=0.
- Read row=30 or col=70 -> BLANK/0/0. Write with row=31 -> w_ready handshake completes and no cell changes.
- Assert rst at cycle 500 of a clear -> busy=0, top_row=0 immediately. With VGA_TEXT_CURSOR_EN: rd_cursor toggles every 16 frame_ticks at (cur_row, cur_col).

Source files
------------

// File: rtl/vga_text_pkg.sv
// Shared types and default geometry for the VGA text buffer.
// Holds the cell layout, the command-engine state encoding and default constants.
package vga_text_pkg;

    localparam int         ROWS_DEF  = 30;
    localparam int         COLS_DEF  = 70;
    localparam int         CLR_W_DEF = 3;
    localparam logic [7:0] BLANK_DEF = 8'h20;

    typedef struct packed {
        logic [7:0]           ascii;
        logic [CLR_W_DEF-1:0] fg;
        logic [CLR_W_DEF-1:0] bg;
    } cell_t;

    typedef enum logic [1:0] {
        IDLE,
        CLEAR,
        SCROLL
    } state_t;

endpackage

// File: rtl/vga_text_ram.sv
// Simple dual-port cell store: one registered read port, one write port.
// A read and a write to the same address on one edge return the old contents.
module vga_text_ram #(
    parameter int DEPTH = 2100,
    parameter int DW    = 14,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [DEPTH];

    // NOTE: neither the array nor the read register is reset, so this maps onto block RAM.
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/vga_text_buf.sv
// Character/attribute buffer with hardware clear and rotating-pointer one-line scroll.
// Define VGA_TEXT_CURSOR_EN to enable the blinking cursor-hit flag on the read port.
module vga_text_buf
    import vga_text_pkg::*;
#(
    parameter int         ROWS  = ROWS_DEF,
    parameter int         COLS  = COLS_DEF,
    parameter int         CLR_W = CLR_W_DEF,
    parameter logic [7:0] BLANK = BLANK_DEF,
    parameter int         RW    = $clog2(ROWS),
    parameter int         CW    = $clog2(COLS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [RW-1:0]    r_row,
    input  logic [CW-1:0]    r_col,
    output logic [7:0]       rd_ascii,
    output logic [CLR_W-1:0] rd_fg,
    output logic [CLR_W-1:0] rd_bg,
    output logic             rd_cursor,
    input  logic             w_valid,
    output logic             w_ready,
    input  logic [RW-1:0]    w_row,
    input  logic [CW-1:0]    w_col,
    input  logic [7:0]       w_ascii,
    input  logic [CLR_W-1:0] w_fg,
    input  logic [CLR_W-1:0] w_bg,
    input  logic             cmd_clear,
    input  logic             cmd_scroll,
    input  logic [CLR_W-1:0] fill_fg,
    input  logic [CLR_W-1:0] fill_bg,
    input  logic [RW-1:0]    cur_row,
    input  logic [CW-1:0]    cur_col,
    input  logic             frame_tick,
    output logic             busy,
    output logic [RW-1:0]    top_row
);

    localparam int            DEPTH      = ROWS * COLS;
    localparam int            AW         = $clog2(DEPTH);
    localparam int            DW         = 8 + 2 * CLR_W;
    localparam logic [RW-1:0] ROW_MAX    = RW'(ROWS - 1);
    localparam logic [CW-1:0] COL_MAX    = CW'(COLS - 1);
    localparam logic [AW-1:0] COLS_A     = AW'(COLS);
    localparam logic [AW-1:0] LAST_A     = AW'(DEPTH - 1);
    localparam logic [AW-1:0] LAST_COL_A = AW'(COLS - 1);

    typedef struct packed {
        logic [7:0]       ascii;
        logic [CLR_W-1:0] fg;
        logic [CLR_W-1:0] bg;
    } cell_w_t;

    state_t           state;
    logic [AW-1:0]    cnt;
    logic [AW-1:0]    scroll_base;
    logic [CLR_W-1:0] fill_fg_q;
    logic [CLR_W-1:0] fill_bg_q;

    logic             ram_we;
    logic [AW-1:0]    ram_waddr;
    cell_w_t          ram_wdata;
    logic [AW-1:0]    ram_raddr;
    cell_w_t          rd_cell;
    logic             r_oob;
    logic             w_oob;
    logic             live_q;
    logic             oob_q;

    // Logical row is rotated by top_row with a compare-and-subtract instead of a modulo.
    function automatic logic [AW-1:0] cell_addr(input logic [RW-1:0] row,
                                                 input logic [CW-1:0] col,
                                                 input logic [RW-1:0] top);
        logic [RW:0] sum;
        logic [RW:0] phys;
        sum  = {1'b0, row} + {1'b0, top};
        phys = (sum > {1'b0, ROW_MAX}) ? sum - (RW+1)'(ROWS) : sum;
        return AW'(phys) * COLS_A + AW'(col);
    endfunction

    assign r_oob     = (r_row > ROW_MAX) || (r_col > COL_MAX);
    assign w_oob     = (w_row > ROW_MAX) || (w_col > COL_MAX);
    assign busy      = (state != IDLE);
    assign w_ready   = (state == IDLE) && !cmd_clear && !cmd_scroll;
    assign ram_raddr = r_oob ? '0 : cell_addr(r_row, r_col, top_row);

    always_comb begin
        ram_we    = 1'b0;
        ram_waddr = cell_addr(w_row, w_col, top_row);
        ram_wdata = '{ascii: w_ascii, fg: w_fg, bg: w_bg};
        case (state)
            IDLE:   ram_we = w_valid && w_ready && !w_oob;
            CLEAR: begin
                ram_we    = 1'b1;
                ram_waddr = cnt;
                ram_wdata = '{ascii: BLANK, fg: fill_fg_q, bg: fill_bg_q};
            end
            SCROLL: begin
                ram_we    = 1'b1;
                ram_waddr = scroll_base + cnt;
                ram_wdata = '{ascii: BLANK, fg: fill_fg_q, bg: fill_bg_q};
            end
            default: ram_we = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            top_row     <= '0;
            cnt         <= '0;
            scroll_base <= '0;
            fill_fg_q   <= '0;
            fill_bg_q   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (cmd_clear) begin
                        state     <= CLEAR;
                        top_row   <= '0;
                        fill_fg_q <= fill_fg;
                        fill_bg_q <= fill_bg;
                    end else if (cmd_scroll) begin
                        // The old top physical row becomes the new, blanked bottom row.
                        state       <= SCROLL;
                        top_row     <= (top_row == ROW_MAX) ? '0 : top_row + 1'b1;
                        scroll_base <= AW'(top_row) * COLS_A;
                        fill_fg_q   <= fill_fg;
                        fill_bg_q   <= fill_bg;
                    end
                end
                CLEAR: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST_A) state <= IDLE;
                end
                SCROLL: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST_COL_A) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    vga_text_ram #(
        .DEPTH (DEPTH),
        .DW    (DW),
        .AW    (AW)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (ram_waddr),
        .wdata (ram_wdata),
        .raddr (ram_raddr),
        .rdata (rd_cell)
    );

    // live_q hides the unreset RAM register until the first post-reset read lands.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            live_q <= 1'b0;
            oob_q  <= 1'b0;
        end else begin
            live_q <= 1'b1;
            oob_q  <= r_oob;
        end
    end

    always_comb begin
        rd_ascii = '0;
        rd_fg    = '0;
        rd_bg    = '0;
        if (live_q) begin
            if (oob_q) begin
                rd_ascii = BLANK;
            end else begin
                rd_ascii = rd_cell.ascii;
                rd_fg    = rd_cell.fg;
                rd_bg    = rd_cell.bg;
            end
        end
    end

`ifdef VGA_TEXT_CURSOR_EN
    logic [4:0] frame_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_cnt <= '0;
            rd_cursor <= 1'b0;
        end else begin
            if (frame_tick) frame_cnt <= frame_cnt + 1'b1;
            rd_cursor <= (r_row == cur_row) && (r_col == cur_col) && frame_cnt[4];
        end
    end
`else
    logic unused_cursor;
    assign unused_cursor = ^{cur_row, cur_col, frame_tick};
    assign rd_cursor     = 1'b0;
`endif

endmodule

// File: tb/tb_vga_text_buf.sv
// Self-checking bench for vga_text_buf against a logical-screen model.
// The model scrolls by shifting rows of a 2-D array; it knows nothing of top-row pointers.
module tb_vga_text_buf;
    import vga_text_pkg::*;

    localparam int         ROWS  = 30;
    localparam int         COLS  = 70;
    localparam int         RW    = 5;
    localparam int         CW    = 7;
    localparam int         CLR_W = 3;
    localparam logic [7:0] BLANK = 8'h20;

    logic             clk = 1'b0;
    logic             rst;
    logic [RW-1:0]    r_row;
    logic [CW-1:0]    r_col;
    logic [7:0]       rd_ascii;
    logic [CLR_W-1:0] rd_fg;
    logic [CLR_W-1:0] rd_bg;
    logic             rd_cursor;
    logic             w_valid;
    logic             w_ready;
    logic [RW-1:0]    w_row;
    logic [CW-1:0]    w_col;
    logic [7:0]       w_ascii;
    logic [CLR_W-1:0] w_fg;
    logic [CLR_W-1:0] w_bg;
    logic             cmd_clear;
    logic             cmd_scroll;
    logic [CLR_W-1:0] fill_fg;
    logic [CLR_W-1:0] fill_bg;
    logic [RW-1:0]    cur_row;
    logic [CW-1:0]    cur_col;
    logic             frame_tick;
    logic             busy;
    logic [RW-1:0]    top_row;

    vga_text_buf dut (
        .clk        (clk),
        .rst        (rst),
        .r_row      (r_row),
        .r_col      (r_col),
        .rd_ascii   (rd_ascii),
        .rd_fg      (rd_fg),
        .rd_bg      (rd_bg),
        .rd_cursor  (rd_cursor),
        .w_valid    (w_valid),
        .w_ready    (w_ready),
        .w_row      (w_row),
        .w_col      (w_col),
        .w_ascii    (w_ascii),
        .w_fg       (w_fg),
        .w_bg       (w_bg),
        .cmd_clear  (cmd_clear),
        .cmd_scroll (cmd_scroll),
        .fill_fg    (fill_fg),
        .fill_bg    (fill_bg),
        .cur_row    (cur_row),
        .cur_col    (cur_col),
        .frame_tick (frame_tick),
        .busy       (busy),
        .top_row    (top_row)
    );

    always #5 clk = ~clk;

    cell_t scr [ROWS][COLS];
    int    model_top = 0;
    int    n_pass    = 0;
    int    n_fail    = 0;
    int    n_total   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear(input logic [2:0] fg, input logic [2:0] bg);
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                scr[r][c] = '{ascii: BLANK, fg: fg, bg: bg};
        model_top = 0;
    endtask

    task automatic model_scroll(input logic [2:0] fg, input logic [2:0] bg);
        for (int r = 0; r < ROWS - 1; r++)
            for (int c = 0; c < COLS; c++)
                scr[r][c] = scr[r+1][c];
        for (int c = 0; c < COLS; c++)
            scr[ROWS-1][c] = '{ascii: BLANK, fg: fg, bg: bg};
        model_top = (model_top + 1) % ROWS;
    endtask

    task automatic read_check(input int row, input int col, input string tag);
        cell_t exp;
        r_row = RW'(row);
        r_col = CW'(col);
        step();
        if (row < ROWS && col < COLS) exp = scr[row][col];
        else                          exp = '{ascii: BLANK, fg: 3'd0, bg: 3'd0};
        check({tag, "_ascii"}, rd_ascii, exp.ascii);
        check({tag, "_fg"},    rd_fg,    exp.fg);
        check({tag, "_bg"},    rd_bg,    exp.bg);
    endtask

    task automatic scan_rows(input int first, input int last, input string tag);
        int bad = 0;
        for (int r = first; r <= last; r++) begin
            for (int c = 0; c < COLS; c++) begin
                r_row = RW'(r);
                r_col = CW'(c);
                step();
                if (rd_ascii !== scr[r][c].ascii || rd_fg !== scr[r][c].fg ||
                    rd_bg !== scr[r][c].bg) bad++;
            end
        end
        check(tag, bad, 0);
    endtask

    task automatic do_write(input int row, input int col, input logic [7:0] a,
                            input logic [2:0] fg, input logic [2:0] bg, input string tag);
        w_valid = 1'b1;
        w_row   = RW'(row);
        w_col   = CW'(col);
        w_ascii = a;
        w_fg    = fg;
        w_bg    = bg;
        check({tag, "_ready"}, w_ready, 1'b1);
        step();
        w_valid = 1'b0;
        if (row < ROWS && col < COLS) scr[row][col] = '{ascii: a, fg: fg, bg: bg};
    endtask

    task automatic pulse_cmd(input logic clr, input logic scl, input logic [2:0] fg, input logic [2:0] bg);
        cmd_clear  = clr;
        cmd_scroll = scl;
        fill_fg    = fg;
        fill_bg    = bg;
        step();
        cmd_clear  = 1'b0;
        cmd_scroll = 1'b0;
        fill_fg    = 3'($urandom);
        fill_bg    = 3'($urandom);
    endtask

    task automatic wait_idle(input string tag, input int exp_len);
        int n = 0;
        bit ready_seen = 1'b0;
        while (busy && n < 5000) begin
            if (w_ready) ready_seen = 1'b1;
            n++;
            step();
        end
        check({tag, "_len"}, n, exp_len);
        check({tag, "_wready_low"}, ready_seen, 1'b0);
    endtask

    task automatic do_scroll(input string tag);
        logic [2:0] fg, bg;
        fg = 3'($urandom);
        bg = 3'($urandom);
        pulse_cmd(1'b0, 1'b1, fg, bg);
        model_scroll(fg, bg);
        wait_idle(tag, COLS);
        check({tag, "_top"}, top_row, model_top);
    endtask

    initial begin
        rst = 1'b1;
        {r_row, r_col, w_valid, w_row, w_col, w_ascii, w_fg, w_bg} = '0;
        {cmd_clear, cmd_scroll, fill_fg, fill_bg, cur_row, cur_col, frame_tick} = '0;
        step();
        step();
        check("rst_busy", busy, 1'b0);
        check("rst_top", top_row, '0);
        check("rst_ascii", rd_ascii, 8'h00);
        check("rst_fg", rd_fg, 3'd0);
        check("rst_bg", rd_bg, 3'd0);
        check("rst_cursor", rd_cursor, 1'b0);
        rst = 1'b0;
        step();
        check("idle_ready", w_ready, 1'b1);

        // Basic write then read
        do_write(2, 5, 8'h41, 3'd7, 3'd1, "wr_A");
        read_check(2, 5, "rd_A");

        // Hardware clear; a pending write during the command must not land
        w_valid = 1'b1;
        w_row   = '0;
        w_col   = '0;
        w_ascii = 8'h51;
        pulse_cmd(1'b1, 1'b0, 3'd0, 3'd2);
        model_clear(3'd0, 3'd2);
        check("clear_top", top_row, '0);
        wait_idle("clear", ROWS * COLS);
        w_valid = 1'b0;
        scan_rows(0, ROWS - 1, "clear_scan");

        // Scroll moves row 1 to row 0 and blanks the bottom
        do_write(1, 9, 8'h58, 3'd5, 3'd3, "wr_X");
        do_scroll("scroll1");
        read_check(0, 9, "rd_X_row0");
        scan_rows(ROWS - 1, ROWS - 1, "scroll_bottom_blank");
        scan_rows(0, ROWS - 1, "scroll_scan");

        // Out-of-range read and write
        read_check(30, 3, "rd_row30");
        read_check(4, 70, "rd_col70");
        do_write(31, 4, 8'h5a, 3'd6, 3'd6, "wr_row31");
        scan_rows(0, ROWS - 1, "oob_write_scan");

        // Randomized mix of writes, reads and scrolls
        for (int i = 0; i < 300; i++) begin
            int op;
            op = $urandom_range(0, 19);
            if (op == 0) do_scroll("rnd_scroll");
            else if (op < 10)
                do_write($urandom_range(0, 31), $urandom_range(0, 71), 8'($urandom),
                         3'($urandom), 3'($urandom), "rnd_wr");
            else read_check($urandom_range(0, 31), $urandom_range(0, 71), "rnd_rd");
        end
        scan_rows(0, ROWS - 1, "random_scan");

        // Thirty scrolls bring the pointer back to zero
        pulse_cmd(1'b1, 1'b0, 3'd1, 3'd4);
        model_clear(3'd1, 3'd4);
        wait_idle("clear2", ROWS * COLS);
        for (int i = 0; i < ROWS; i++) begin
            do_write(ROWS - 1, i, 8'h30 + 8'(i), 3'(i), 3'(i + 1), "wrap_wr");
            do_scroll("wrap_scroll");
        end
        check("wrap_top_zero", top_row, '0);
        scan_rows(0, ROWS - 1, "wrap_scan");

        // Clear and scroll together: clear wins
        do_scroll("pre_both");
        pulse_cmd(1'b1, 1'b1, 3'd6, 3'd5);
        model_clear(3'd6, 3'd5);
        check("both_top", top_row, '0);
        wait_idle("both", ROWS * COLS);
        for (int i = 0; i < 4; i++)
            read_check($urandom_range(0, ROWS - 1), $urandom_range(0, COLS - 1), "both_rd");

        // Cursor flag
        cur_row = 5'd3;
        cur_col = 7'd11;
        r_row   = 5'd3;
        r_col   = 7'd11;
        for (int t = 1; t <= 32; t++) begin
            frame_tick = 1'b1;
            step();
            frame_tick = 1'b0;
            step();
            if (t == 15 || t == 16 || t == 31 || t == 32) begin
`ifdef VGA_TEXT_CURSOR_EN
                check("cursor_phase", rd_cursor, (t % 32) >= 16);
`else
                check("cursor_off", rd_cursor, 1'b0);
`endif
            end
        end
        r_col = 7'd12;
        step();
        check("cursor_miss", rd_cursor, 1'b0);

        // Reset in the middle of a clear
        do_scroll("pre_rst");
        pulse_cmd(1'b1, 1'b0, 3'd3, 3'd3);
        for (int i = 0; i < 499; i++) step();
        check("mid_clear_busy", busy, 1'b1);
        rst = 1'b1;
        #1;
        check("rst_mid_busy", busy, 1'b0);
        check("rst_mid_top", top_row, '0);
        check("rst_mid_ascii", rd_ascii, 8'h00);
        step();
        rst = 1'b0;
        step();
        step();
        check("post_rst_busy", busy, 1'b0);
        check("post_rst_ready", w_ready, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
